periph_async_ack: RTL and testbench
===================================

// Module: periph_async_ack
// PURPOSE
//  Responder end of the send/ack four-phase handshake driven by the CPU-side initiator.
//  Synchronises send and captures data_in (bundled data) into a small FIFO.
//  Acknowledges each word and presents buffered words to a local consumer via valid/ready.
//  Sits on the peripheral side of the CPU-to-peripheral link, in its own clock domain.
// PARAMETERS
//  DATA_W       8  width of data_in / out_data
//  FIFO_DEPTH   4  buffer entries; power of two, >=2
//  SYNC_STAGES  2  flops in the send synchroniser; >=2
// PORTS
//  clk        in   1                  peripheral clock, all logic on rising edge
//  rst_n      in   1                  asynchronous reset, active low
//  send       in   1                  request from initiator (async to clk)
//  data_in    in   DATA_W             bundled data; stable from send rise until ack rise
//  ack        out  1                  acknowledge to initiator, registered
//  out_data   out  DATA_W             FIFO head word
//  out_valid  out  1                  FIFO non-empty
//  out_ready  in   1                  consumer accepts head when out_valid & out_ready
//  fifo_count out  clog2(FIFO_DEPTH)+1 entries currently held
// BEHAVIOUR
//  Reset (rst_n=0, immediate): ack=0, out_valid=0, fifo_count=0, pointers=0, sync chain=0, FSM=IDLE.
//  Sync: send passes SYNC_STAGES flops -> send_s; data_in is never synchronised, only sampled.
//  FSM (registered ack = (state==ACK_HI)):
//   IDLE   : ack=0. If send_s=1 and FIFO not full: write data_in into FIFO, go ACK_HI.
//            If send_s=1 and full: stay IDLE, ack held 0 (backpressure, no word dropped).
//   ACK_HI : ack=1. Stay while send_s=1. On send_s=0 go IDLE.
//  Latency: first edge sampling send=1 = edge k -> ack high after edge k+SYNC_STAGES (not full).
//   Same for release: first edge sampling send=0 = edge j -> ack low after edge j+SYNC_STAGES.
//   Exactly one FIFO write per send high phase.
//  FIFO: first-word-fall-through; out_data = mem[rd_ptr]; out_valid = (count!=0).
//   Pop when out_valid & out_ready. Pointers wrap modulo FIFO_DEPTH.
//   Full test in IDLE uses the current count; a same-cycle pop does NOT free space for
//   the push (push waits one cycle). Push+pop same cycle when not full: count unchanged.
//   Pop when empty is ignored; out_data is don't-care when out_valid=0.
//  Reset mid-handshake: ack drops immediately and buffered words are lost. If send is still
//   high after reset release, it is treated as a new request (word captured again).
//  out_ready may toggle freely; the handshake side is independent of consumer stalls
//   except through the full condition.
// CONFIGURATION
//  PARITY_CHECK_EN defined: adds ports parity_in (in,1; even parity over data_in, same
//   bundling as data_in), parity_err (out,1; one-cycle pulse) and err_cnt (out,8;
//   saturating at 255, reset 0). On capture with parity mismatch, the word is NOT written
//   but ack is still raised normally; parity_err pulses in the capture cycle and err_cnt
//   increments. A mismatching word is acknowledged even when the FIFO is full.
//  PARITY_CHECK_EN undefined: no parity ports, every captured word is written.
// TESTING
//  1 Single word: send=1 with data_in=8'hA5 -> ack high SYNC_STAGES edges later;
//    out_valid=1 with out_data=8'hA5; send=0 -> ack low; fifo_count=1.
//  2 Burst of 4 words 01,02,03,04 with out_ready=0 -> all acked, fifo_count=4;
//    5th send 05 -> ack stays 0; raise out_ready for one pop -> 05 acked;
//    drain order 02,03,04,05.
//  3 Streaming with out_ready=1 over 10 words 00..09 -> output order matches, no loss;
//    fifo_count never exceeds 1 after settling; pointer wrap exercised.
//  4 Full with push and pop on the same edge -> push deferred one cycle, count 4->3->4,
//    no word lost or duplicated.
//  5 Assert rst_n=0 while ack=1 and 2 words buffered -> ack=0, out_valid=0 immediately;
//    release with send=1, data_in=8'h3C -> single word 3C captured and acked.
//  6 PARITY_CHECK_EN: send data 8'h01 with parity_in=0 -> acked, not buffered,
//    parity_err pulses once, err_cnt=1; then 8'h03 with parity_in=0 -> buffered.

Source files
------------

// File: rtl/periph_async_ack.sv
// Responder side of a four-phase send/ack handshake: synchronises send, buffers bundled data
// in a FWFT FIFO for a valid/ready consumer. Optional parity checking via `PARITY_CHECK_EN.
module periph_async_ack #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            send,
    input  logic [DATA_W-1:0]               data_in,
`ifdef PARITY_CHECK_EN
    input  logic                            parity_in,
    output logic                            parity_err,
    output logic [7:0]                      err_cnt,
`endif
    output logic                            ack,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    send_s;
    logic                    ack_q;
    logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    full_s, pop_s, push_s, capture_s, parity_bad_s;

`ifdef PARITY_CHECK_EN
    logic                    parity_err_q;
    logic [7:0]              err_cnt_q;

    function automatic logic even_parity_bad(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    assign parity_bad_s = even_parity_bad(data_in, parity_in);
    assign parity_err   = parity_err_q;
    assign err_cnt      = err_cnt_q;
`else
    assign parity_bad_s = 1'b0;
`endif

    assign send_s     = sync_q[SYNC_STAGES-1];
    assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s      = (count_q != {CNT_W{1'b0}}) && out_ready;
    assign push_s     = capture_s && !parity_bad_s;
    assign ack        = ack_q;
    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != {CNT_W{1'b0}});
    assign fifo_count = count_q;

    // Synchroniser for the asynchronous send request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], send};
        end
    end

    // Handshake next-state; a full FIFO holds off the ack unless the word is to be discarded.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_s && (!full_s || parity_bad_s)) begin
                    capture_s = 1'b1;
                    state_d   = ACK_HI;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACK_HI: begin
                if (!send_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State, ack and FIFO pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACK_HI);
            count_q <= count_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // FIFO storage; contents are meaningless until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity error pulse and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            parity_err_q <= capture_s && parity_bad_s;
            if (capture_s && parity_bad_s && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_periph_async_ack.sv
// Directed self-checking bench for periph_async_ack (default parameters).
// Parity scenario is included when PARITY_CHECK_EN is defined.
module tb_periph_async_ack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fifo_count;
`ifdef PARITY_CHECK_EN
    logic       parity_in = 1'b0;
    logic       parity_err;
    logic [7:0] err_cnt;
`endif

    int ncmp = 0;
    int nerr = 0;
    bit mon_en = 1'b0;
    logic [7:0] popq[$];
    logic [2:0] cntq[$];

    periph_async_ack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send       (send),
        .data_in    (data_in),
`ifdef PARITY_CHECK_EN
        .parity_in  (parity_in),
        .parity_err (parity_err),
        .err_cnt    (err_cnt),
`endif
        .ack        (ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Records consumer pops and occupancy while monitoring is enabled.
    always @(posedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) popq.push_back(out_data);
            cntq.push_back(fifo_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input int max_cyc);
        for (int i = 0; i < max_cyc && ack !== lvl; i++) tick();
    endtask

    task automatic xfer(input logic [7:0] d, input string tag);
        send = 1'b1;
        data_in = d;
`ifdef PARITY_CHECK_EN
        parity_in = ^d;
`endif
        wait_ack(1'b1, 20);
        check({tag, "_ack_hi"}, ack, 1'b1);
        send = 1'b0;
        wait_ack(1'b0, 20);
        check({tag, "_ack_lo"}, ack, 1'b0);
    endtask

    initial begin
        int mx;
        // Reset state
        #2;
        check("rst_ack", ack, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single word with exact latency
        send = 1'b1;
        data_in = 8'hA5;
`ifdef PARITY_CHECK_EN
        parity_in = ^data_in;
`endif
        tick(); tick();
        check("t1_ack_early", ack, 1'b0);
        tick();
        check("t1_ack_hi", ack, 1'b1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 8'hA5);
        send = 1'b0;
        tick(); tick();
        check("t1_ack_hold", ack, 1'b1);
        tick();
        check("t1_ack_lo", ack, 1'b0);
        check("t1_count", fifo_count, 3'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_drain", fifo_count, 3'd0);

        // 2/4: fill, backpressure, pop-then-deferred-push
        for (int i = 1; i <= 4; i++) xfer(8'(i), "t2_fill");
        check("t2_count4", fifo_count, 3'd4);
        send = 1'b1;
        data_in = 8'h05;
`ifdef PARITY_CHECK_EN
        parity_in = ^data_in;
`endif
        for (int i = 0; i < 6; i++) tick();
        check("t2_bp_ack", ack, 1'b0);
        check("t2_bp_count", fifo_count, 3'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_pop_count", fifo_count, 3'd3);
        check("t4_pop_ack", ack, 1'b0);
        check("t4_head", out_data, 8'h02);
        tick();
        check("t4_push_ack", ack, 1'b1);
        check("t4_push_count", fifo_count, 3'd4);
        send = 1'b0;
        wait_ack(1'b0, 20);
        check("t2_ack_lo", ack, 1'b0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("t2_drain_valid", out_valid, 1'b1);
            check("t2_drain_data", out_data, 8'(i));
            tick();
        end
        check("t2_empty", out_valid, 1'b0);

        // 3: streaming with out_ready held high
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) xfer(8'(i), "t3");
        tick(); tick();
        mon_en = 1'b0;
        check("t3_popcnt", popq.size(), 32'd10);
        for (int i = 0; i < 10 && i < popq.size(); i++) check("t3_order", popq[i], 8'(i));
        mx = 0;
        foreach (cntq[i]) if (int'(cntq[i]) > mx) mx = int'(cntq[i]);
        check("t3_maxcount", mx, 32'd1);
        out_ready = 1'b0;

        // 5: reset mid-handshake with send still asserted
        xfer(8'hAA, "t5_pre");
        send = 1'b1;
        data_in = 8'hBB;
`ifdef PARITY_CHECK_EN
        parity_in = ^data_in;
`endif
        wait_ack(1'b1, 20);
        check("t5_ack_before", ack, 1'b1);
        check("t5_count_before", fifo_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ack", ack, 1'b0);
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_count", fifo_count, 3'd0);
        data_in = 8'h3C;
`ifdef PARITY_CHECK_EN
        parity_in = ^data_in;
`endif
        tick();
        rst_n = 1'b1;
        wait_ack(1'b1, 20);
        check("t5_ack_hi", ack, 1'b1);
        check("t5_data", out_data, 8'h3C);
        check("t5_count", fifo_count, 3'd1);
        send = 1'b0;
        wait_ack(1'b0, 20);
        check("t5_ack_lo", ack, 1'b0);
        check("t5_single", fifo_count, 3'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_drain", fifo_count, 3'd0);

`ifdef PARITY_CHECK_EN
        // 6: parity error word acknowledged but dropped
        send = 1'b1;
        data_in = 8'h01;
        parity_in = 1'b0;
        wait_ack(1'b1, 20);
        check("t6_ack", ack, 1'b1);
        check("t6_perr", parity_err, 1'b1);
        check("t6_errcnt", err_cnt, 8'd1);
        check("t6_count", fifo_count, 3'd0);
        tick();
        check("t6_perr_pulse", parity_err, 1'b0);
        send = 1'b0;
        wait_ack(1'b0, 20);
        send = 1'b1;
        data_in = 8'h03;
        parity_in = 1'b0;
        wait_ack(1'b1, 20);
        check("t6_ok_ack", ack, 1'b1);
        check("t6_ok_count", fifo_count, 3'd1);
        check("t6_ok_data", out_data, 8'h03);
        check("t6_ok_errcnt", err_cnt, 8'd1);
        send = 1'b0;
        wait_ack(1'b0, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
